// File: rtl/lane_packet_classifier_pkg.sv
// Shared constants for the lane packet classifier: K-symbol bytes,
// per-lane class codes, membership codes and the framing state enum.
package lane_packet_classifier_pkg;

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_PAD = 8'hF7;

  localparam logic [2:0] TY_DATA      = 3'b000;
  localparam logic [2:0] TY_TLPSTART  = 3'b001;
  localparam logic [2:0] TY_TLPEND    = 3'b010;
  localparam logic [2:0] TY_DLLPSTART = 3'b011;
  localparam logic [2:0] TY_DLLPEND   = 3'b100;
  localparam logic [2:0] TY_TLPEDB    = 3'b101;
  localparam logic [2:0] TY_ERROR     = 3'b110;
  localparam logic [2:0] TY_NOT_VALID = 3'b111;

  localparam logic [1:0] MB_NONE = 2'b00;
  localparam logic [1:0] MB_TLP  = 2'b01;
  localparam logic [1:0] MB_DLLP = 2'b10;

  // A DLLP body is exactly six data bytes between SDP and END.
  localparam logic [2:0] DLLP_LAST = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IN_TLP  = 2'd1,
    ST_IN_DLLP = 2'd2
  } state_e;

endpackage

// File: rtl/lane_packet_classifier_lane_step.sv
// One lane of the classifier chain: purely combinational framing step.
//
// state      | meaning
// -----------+------------------------------------------
// ST_IDLE    | between packets, expecting STP or SDP
// ST_IN_TLP  | inside a TLP, waiting for END or EDB
// ST_IN_DLLP | inside a DLLP, counting six data bytes
module lane_step
  import lane_packet_classifier_pkg::*;
(
  input  state_e      state_i,
  input  logic [2:0]  cnt_i,
  input  logic [7:0]  byte_i,
  input  logic        k_i,
  output state_e      state_o,
  output logic [2:0]  cnt_o,
  output logic [2:0]  type_o,
  output logic [1:0]  memb_o,
  output logic        err_o,
  output logic        tlp_done_o,
  output logic        dllp_done_o
);

  // Classify this lane's symbol and advance the framing state.
  always_comb begin
    state_o     = state_i;
    cnt_o       = cnt_i;
    type_o      = TY_NOT_VALID;
    memb_o      = MB_NONE;
    err_o       = 1'b0;
    tlp_done_o  = 1'b0;
    dllp_done_o = 1'b0;
    case (state_i)
      ST_IDLE: begin
        if (!k_i) begin
          type_o = TY_ERROR;
          err_o  = 1'b1;
        end else if (byte_i == K_STP) begin
          type_o  = TY_TLPSTART;
          memb_o  = MB_TLP;
          state_o = ST_IN_TLP;
        end else if (byte_i == K_SDP) begin
          type_o  = TY_DLLPSTART;
          memb_o  = MB_DLLP;
          state_o = ST_IN_DLLP;
          cnt_o   = 3'd0;
        end
        // Any other K symbol between packets (PAD, stray END/EDB, ...) is filler.
      end
      ST_IN_TLP: begin
        memb_o = MB_TLP;
        if (!k_i) begin
          type_o = TY_DATA;
        end else if (byte_i == K_END) begin
          type_o     = TY_TLPEND;
          state_o    = ST_IDLE;
          tlp_done_o = 1'b1;
        end else if (byte_i == K_EDB) begin
          type_o  = TY_TLPEDB;
          state_o = ST_IDLE;
        end else begin
          type_o  = TY_ERROR;
          err_o   = 1'b1;
          state_o = ST_IDLE;
        end
      end
      ST_IN_DLLP: begin
        memb_o = MB_DLLP;
        if (!k_i && cnt_i < DLLP_LAST) begin
          type_o = TY_DATA;
          cnt_o  = cnt_i + 3'd1;
        end else if (k_i && byte_i == K_END && cnt_i == DLLP_LAST) begin
          type_o      = TY_DLLPEND;
          state_o     = ST_IDLE;
          dllp_done_o = 1'b1;
        end else begin
          type_o  = TY_ERROR;
          err_o   = 1'b1;
          state_o = ST_IDLE;
        end
      end
      default: state_o = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/lane_packet_classifier.sv
// Multi-lane packet classifier: chains one lane_step per lane, registers
// the per-lane results and keeps saturating packet/error statistics.
module lane_packet_classifier
  import lane_packet_classifier_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8*LANES-1:0]   data_in,
  input  logic [LANES-1:0]     DK,
  input  logic                 valid,
  output logic [3*LANES-1:0]   type_out,
  output logic [2*LANES-1:0]   tlp_or_dllp_out,
  output logic                 frame_err,
  output logic [CNT_W-1:0]     tlp_cnt,
  output logic [CNT_W-1:0]     dllp_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int SUM_W = CNT_W + 4;

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [3*LANES-1:0] type_q, type_d;
  logic [2*LANES-1:0] memb_q, memb_d;
  logic               frame_err_q, frame_err_d;
  logic [CNT_W-1:0]   tlp_cnt_q, tlp_cnt_d;
  logic [CNT_W-1:0]   dllp_cnt_q, dllp_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  state_e     st_c  [LANES+1];
  logic [2:0] cnt_c [LANES+1];
  logic [2:0] ty_l  [LANES];
  logic [1:0] mb_l  [LANES];
  logic       err_l [LANES];
  logic       tlp_l [LANES];
  logic       dllp_l[LANES];

  logic [3:0] n_err, n_tlp, n_dllp;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [3:0] inc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(c) + SUM_W'(inc);
    if (s > SUM_W'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  assign st_c[0]  = state_q;
  assign cnt_c[0] = cnt_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_step u_step (
      .state_i     (st_c[i]),
      .cnt_i       (cnt_c[i]),
      .byte_i      (data_in[8*i +: 8]),
      .k_i         (DK[i]),
      .state_o     (st_c[i+1]),
      .cnt_o       (cnt_c[i+1]),
      .type_o      (ty_l[i]),
      .memb_o      (mb_l[i]),
      .err_o       (err_l[i]),
      .tlp_done_o  (tlp_l[i]),
      .dllp_done_o (dllp_l[i])
    );
  end

  // Collect lane results and compute next registered state and statistics.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    type_d      = {LANES{TY_NOT_VALID}};
    memb_d      = {LANES{MB_NONE}};
    frame_err_d = 1'b0;
    tlp_cnt_d   = tlp_cnt_q;
    dllp_cnt_d  = dllp_cnt_q;
    err_cnt_d   = err_cnt_q;
    n_err       = 4'd0;
    n_tlp       = 4'd0;
    n_dllp      = 4'd0;
    for (int i = 0; i < LANES; i++) begin
      n_err  = n_err  + 4'(err_l[i]);
      n_tlp  = n_tlp  + 4'(tlp_l[i]);
      n_dllp = n_dllp + 4'(dllp_l[i]);
    end
    if (valid) begin
      state_d = st_c[LANES];
      cnt_d   = cnt_c[LANES];
      for (int i = 0; i < LANES; i++) begin
        type_d[3*i +: 3] = ty_l[i];
        memb_d[2*i +: 2] = mb_l[i];
      end
      frame_err_d = (n_err != 4'd0);
      tlp_cnt_d   = sat_add(tlp_cnt_q, n_tlp);
      dllp_cnt_d  = sat_add(dllp_cnt_q, n_dllp);
      err_cnt_d   = sat_add(err_cnt_q, n_err);
    end
  end

  // Registers; reset drops any packet in flight without counting it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      type_q      <= {LANES{TY_NOT_VALID}};
      memb_q      <= {LANES{MB_NONE}};
      frame_err_q <= 1'b0;
      tlp_cnt_q   <= '0;
      dllp_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      type_q      <= type_d;
      memb_q      <= memb_d;
      frame_err_q <= frame_err_d;
      tlp_cnt_q   <= tlp_cnt_d;
      dllp_cnt_q  <= dllp_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign type_out        = type_q;
  assign tlp_or_dllp_out = memb_q;
  assign frame_err       = frame_err_q;
  assign tlp_cnt         = tlp_cnt_q;
  assign dllp_cnt        = dllp_cnt_q;
  assign err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_lane_packet_classifier.sv
// Directed bench for lane_packet_classifier (4 lanes, 16-bit and 2-bit counters).
module tb_lane_packet_classifier;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] ENDK = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] PAD = 8'hF7;
  localparam logic [7:0] D   = 8'h3A;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic [3:0]  dk;
  logic        valid;

  logic [11:0] type_a;
  logic [7:0]  memb_a;
  logic        ferr_a;
  logic [15:0] tlp_a, dllp_a, err_a;

  logic [11:0] type_b;
  logic [7:0]  memb_b;
  logic        ferr_b;
  logic [1:0]  tlp_b, dllp_b, err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lane_packet_classifier #(.LANES(4), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .data_in(data_in), .DK(dk), .valid(valid),
    .type_out(type_a), .tlp_or_dllp_out(memb_a), .frame_err(ferr_a),
    .tlp_cnt(tlp_a), .dllp_cnt(dllp_a), .err_cnt(err_a)
  );

  lane_packet_classifier #(.LANES(4), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .data_in(data_in), .DK(dk), .valid(valid),
    .type_out(type_b), .tlp_or_dllp_out(memb_b), .frame_err(ferr_b),
    .tlp_cnt(tlp_b), .dllp_cnt(dllp_b), .err_cnt(err_b)
  );

  function automatic logic [31:0] d4(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [11:0] t4(input logic [2:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [7:0] m4(input logic [1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one input cycle and sample the registered result 1 time unit later.
  task automatic cyc(input logic [31:0] d, input logic [3:0] k, input logic v);
    data_in = d;
    dk      = k;
    valid   = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid = 1'b1;
    data_in = d4(STP, D, D, D);
    dk = 4'b0001;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    data_in = '0;
    dk = '0;
    valid = 1'b0;
    @(negedge clk);

    // Reset state (valid held high to show reset wins).
    do_reset();
    chk("rst_type", 32'(type_a), 32'hFFF);
    chk("rst_memb", 32'(memb_a), 32'h00);
    chk("rst_ferr", 32'(ferr_a), 32'h0);
    chk("rst_tlp",  32'(tlp_a), 32'h0);
    chk("rst_dllp", 32'(dllp_a), 32'h0);
    chk("rst_err",  32'(err_a), 32'h0);

    // Whole TLP in one cycle.
    cyc(d4(STP, D, D, ENDK), 4'b1001, 1'b1);
    chk("tlp1_type", 32'(type_a), 32'(t4(3'b001, 3'b000, 3'b000, 3'b010)));
    chk("tlp1_memb", 32'(memb_a), 32'(m4(2'b01, 2'b01, 2'b01, 2'b01)));
    chk("tlp1_cnt",  32'(tlp_a), 32'd1);
    chk("tlp1_ferr", 32'(ferr_a), 32'd0);

    // DLLP spanning three cycles.
    cyc(d4(PAD, SDP, D, D), 4'b0011, 1'b1);
    chk("dl1_type", 32'(type_a), 32'(t4(3'b111, 3'b011, 3'b000, 3'b000)));
    chk("dl1_memb", 32'(memb_a), 32'(m4(2'b00, 2'b10, 2'b10, 2'b10)));
    cyc(d4(D, D, D, D), 4'b0000, 1'b1);
    chk("dl2_type", 32'(type_a), 32'(t4(3'b000, 3'b000, 3'b000, 3'b000)));
    chk("dl2_memb", 32'(memb_a), 32'(m4(2'b10, 2'b10, 2'b10, 2'b10)));
    cyc(d4(ENDK, PAD, PAD, PAD), 4'b1111, 1'b1);
    chk("dl3_type", 32'(type_a), 32'(t4(3'b100, 3'b111, 3'b111, 3'b111)));
    chk("dl3_memb", 32'(memb_a), 32'(m4(2'b10, 2'b00, 2'b00, 2'b00)));
    chk("dl3_dcnt", 32'(dllp_a), 32'd1);
    chk("dl3_ecnt", 32'(err_a), 32'd0);

    // Short DLLP: SDP + 5 data + END is a framing error.
    cyc(d4(SDP, D, D, D), 4'b0001, 1'b1);
    cyc(d4(D, D, ENDK, PAD), 4'b1100, 1'b1);
    chk("dls_type", 32'(type_a), 32'(t4(3'b000, 3'b000, 3'b110, 3'b111)));
    chk("dls_memb", 32'(memb_a), 32'(m4(2'b10, 2'b10, 2'b10, 2'b00)));
    chk("dls_ferr", 32'(ferr_a), 32'd1);
    chk("dls_ecnt", 32'(err_a), 32'd1);
    chk("dls_dcnt", 32'(dllp_a), 32'd1);

    // TLP interrupted by three idle cycles, then EDB and a new TLP start.
    cyc(d4(STP, D, D, D), 4'b0001, 1'b1);
    chk("nv0_ferr", 32'(ferr_a), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(d4(ENDK, ENDK, ENDK, ENDK), 4'b1111, 1'b0);
      chk("nv_type", 32'(type_a), 32'hFFF);
      chk("nv_memb", 32'(memb_a), 32'h00);
      chk("nv_ferr", 32'(ferr_a), 32'd0);
    end
    cyc(d4(D, EDB, STP, D), 4'b0110, 1'b1);
    chk("edb_type", 32'(type_a), 32'(t4(3'b000, 3'b101, 3'b001, 3'b000)));
    chk("edb_memb", 32'(memb_a), 32'(m4(2'b01, 2'b01, 2'b01, 2'b01)));
    chk("edb_tcnt", 32'(tlp_a), 32'd1);
    cyc(d4(ENDK, PAD, PAD, PAD), 4'b1111, 1'b1);
    chk("edb2_type", 32'(type_a), 32'(t4(3'b010, 3'b111, 3'b111, 3'b111)));
    chk("edb2_tcnt", 32'(tlp_a), 32'd2);

    // DLLP with a seventh data byte.
    cyc(d4(SDP, D, D, D), 4'b0001, 1'b1);
    cyc(d4(D, D, D, D), 4'b0000, 1'b1);
    chk("dl7_type", 32'(type_a), 32'(t4(3'b000, 3'b000, 3'b000, 3'b110)));
    chk("dl7_ecnt", 32'(err_a), 32'd2);

    // Reset in the middle of a TLP; leftover symbols are not part of a packet.
    cyc(d4(STP, D, D, D), 4'b0001, 1'b1);
    do_reset();
    chk("mr_tcnt", 32'(tlp_a), 32'd0);
    chk("mr_dcnt", 32'(dllp_a), 32'd0);
    chk("mr_ecnt", 32'(err_a), 32'd0);
    cyc(d4(ENDK, D, PAD, PAD), 4'b1101, 1'b1);
    chk("mr2_type", 32'(type_a), 32'(t4(3'b111, 3'b110, 3'b111, 3'b111)));
    chk("mr2_memb", 32'(memb_a), 32'h00);
    chk("mr2_ecnt", 32'(err_a), 32'd1);
    chk("mr2_ferr", 32'(ferr_a), 32'd1);
    chk("mr2_tcnt", 32'(tlp_a), 32'd0);
    chk("mr2_becnt", 32'(err_b), 32'd1);

    // Stray data bytes in IDLE: four errors per cycle; 2-bit counter saturates.
    cyc(d4(D, D, D, D), 4'b0000, 1'b1);
    chk("sat1_aecnt", 32'(err_a), 32'd5);
    chk("sat1_becnt", 32'(err_b), 32'd3);
    cyc(d4(D, D, D, D), 4'b0000, 1'b1);
    chk("sat2_aecnt", 32'(err_a), 32'd9);
    chk("sat2_becnt", 32'(err_b), 32'd3);
    cyc(d4(PAD, PAD, PAD, PAD), 4'b1111, 1'b1);
    chk("sat3_ferr", 32'(ferr_a), 32'd0);
    chk("sat3_becnt", 32'(err_b), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
